// File: rtl/mdio_master_if.sv
// Request/response and pin bundle between the MDIO master, its requester and the PHY pin.
// The master modport is the mdio_master side; slave is the requester/pin side.
interface mdio_master_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [4:0]  Req_PhyAddr;
  logic [4:0]  Req_RegAddr;
  logic [15:0] Req_WrData;
  logic        Rsp_Valid;
  logic [15:0] Rsp_RdData;
  logic        Rsp_Err;
  logic        Busy;
  logic        MDIO_O;
  logic        MDIO_T;
  logic        MDIO_I;

  modport master (
    input  Req_Valid, Req_Write, Req_PhyAddr, Req_RegAddr, Req_WrData, MDIO_I,
    output Req_Ready, Rsp_Valid, Rsp_RdData, Rsp_Err, Busy, MDIO_O, MDIO_T
  );

  modport slave (
    output Req_Valid, Req_Write, Req_PhyAddr, Req_RegAddr, Req_WrData, MDIO_I,
    input  Req_Ready, Rsp_Valid, Rsp_RdData, Rsp_Err, Busy, MDIO_O, MDIO_T
  );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master in the MDC domain: serialises one read/write frame per request,
// retimes the pin on the falling edge and returns read data with a one-cycle strobe.
module mdio_master #(
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned IDLE_GAP     = 2
) (
  input logic            MDC_Clk,
  input logic            MDC_Rst,
  mdio_master_if.master  bus
);

  localparam logic [3:0] StReset = 4'd0;
  localparam logic [3:0] StIdle  = 4'd1;
  localparam logic [3:0] StPre   = 4'd2;
  localparam logic [3:0] StSt    = 4'd3;
  localparam logic [3:0] StOp    = 4'd4;
  localparam logic [3:0] StPhy   = 4'd5;
  localparam logic [3:0] StReg   = 4'd6;
  localparam logic [3:0] StTa    = 4'd7;
  localparam logic [3:0] StData  = 4'd8;
  localparam logic [3:0] StDone  = 4'd9;
  localparam logic [3:0] StGap   = 4'd10;

  localparam logic [5:0] PreLoad = 6'(PREAMBLE_LEN - 1);
  // DONE already counts as the first released gap cycle.
  localparam logic [5:0] GapLoad = 6'(IDLE_GAP - 2);

  logic [3:0]  state, stateNext;
  logic [5:0]  bitCnt, bitCntNext;
  logic        reqWrite;
  logic [4:0]  phyAddr, regAddr;
  logic [15:0] wrData;
  logic [14:0] rdShift;
  logic        taErr;
  logic [15:0] rdData;
  logic        rspErr;
  logic        frameO, frameT;
  logic        pinO, pinT;
  logic        fieldEnd;

  assign fieldEnd = (bitCnt == 6'd0);

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt - 6'd1;
    case (state)
      StReset: stateNext = StIdle;
      StIdle: begin
        bitCntNext = bitCnt;
        if (bus.Req_Valid) begin
          if (PREAMBLE_LEN > 0) begin
            stateNext  = StPre;
            bitCntNext = PreLoad;
          end else begin
            stateNext  = StSt;
            bitCntNext = 6'd1;
          end
        end
      end
      StPre:  if (fieldEnd) begin stateNext = StSt;   bitCntNext = 6'd1;  end
      StSt:   if (fieldEnd) begin stateNext = StOp;   bitCntNext = 6'd1;  end
      StOp:   if (fieldEnd) begin stateNext = StPhy;  bitCntNext = 6'd4;  end
      StPhy:  if (fieldEnd) begin stateNext = StReg;  bitCntNext = 6'd4;  end
      StReg:  if (fieldEnd) begin stateNext = StTa;   bitCntNext = 6'd1;  end
      StTa:   if (fieldEnd) begin stateNext = StData; bitCntNext = 6'd15; end
      StData: if (fieldEnd) begin stateNext = StDone; bitCntNext = 6'd0;  end
      StDone: begin
        if (IDLE_GAP > 1) begin
          stateNext  = StGap;
          bitCntNext = GapLoad;
        end else begin
          stateNext  = StIdle;
          bitCntNext = 6'd0;
        end
      end
      StGap: begin
        if (fieldEnd) begin
          stateNext  = StIdle;
          bitCntNext = 6'd0;
        end
      end
      default: begin
        stateNext  = StIdle;
        bitCntNext = 6'd0;
      end
    endcase
  end

  // Frame bit for the current cycle; the counter indexes each field MSB first.
  always_comb begin
    frameO = 1'b1;
    frameT = 1'b1;
    case (state)
      StPre: frameT = 1'b0;
      StSt: begin
        frameO = ~bitCnt[0];
        frameT = 1'b0;
      end
      StOp: begin
        frameO = reqWrite ? ~bitCnt[0] : bitCnt[0];
        frameT = 1'b0;
      end
      StPhy: begin
        frameO = phyAddr[bitCnt[2:0]];
        frameT = 1'b0;
      end
      StReg: begin
        frameO = regAddr[bitCnt[2:0]];
        frameT = 1'b0;
      end
      StTa: begin
        if (reqWrite) begin
          frameO = bitCnt[0];
          frameT = 1'b0;
        end
      end
      StData: begin
        if (reqWrite) begin
          frameO = wrData[bitCnt[3:0]];
          frameT = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MDC_Clk or posedge MDC_Rst) begin
    if (MDC_Rst) begin
      state    <= StReset;
      bitCnt   <= 6'd0;
      reqWrite <= 1'b0;
      phyAddr  <= 5'd0;
      regAddr  <= 5'd0;
      wrData   <= 16'd0;
      rdShift  <= 15'd0;
      taErr    <= 1'b0;
      rdData   <= 16'd0;
      rspErr   <= 1'b0;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
      if (state == StIdle && bus.Req_Valid) begin
        reqWrite <= bus.Req_Write;
        phyAddr  <= bus.Req_PhyAddr;
        regAddr  <= bus.Req_RegAddr;
        wrData   <= bus.Req_WrData;
      end
      // The PHY must pull the second turnaround bit low on reads.
      if (state == StTa && fieldEnd && !reqWrite) begin
        taErr <= bus.MDIO_I;
      end
      if (state == StData) begin
        rdShift <= {rdShift[13:0], bus.MDIO_I};
        if (fieldEnd) begin
          rdData <= reqWrite ? 16'd0 : {rdShift, bus.MDIO_I};
          rspErr <= reqWrite ? 1'b0 : taErr;
        end
      end
    end
  end

  // Falling-edge retiming centres the pin value on the PHY's rising-edge sample.
  always_ff @(negedge MDC_Clk or posedge MDC_Rst) begin
    if (MDC_Rst) begin
      pinO <= 1'b1;
      pinT <= 1'b1;
    end else begin
      pinO <= frameO;
      pinT <= frameT;
    end
  end

  assign bus.Req_Ready  = (state == StIdle);
  assign bus.Busy       = (state != StIdle) && (state != StReset);
  assign bus.Rsp_Valid  = (state == StDone);
  assign bus.Rsp_RdData = rdData;
  assign bus.Rsp_Err    = rspErr;
  assign bus.MDIO_O     = pinO;
  assign bus.MDIO_T     = pinT;

endmodule
